// File: rtl/heatmap_pkg.sv
// Shared constants and FSM encoding for the heat-map column stores.
package heatmap_pkg;

    localparam int COLS   = 100;
    localparam int ROWS   = 480;
    localparam int DATA_W = 8;
    localparam int ROW_W  = 10;

    localparam logic signed [7:0] SAT_MAX = 8'sd127;
    localparam logic signed [7:0] SAT_MIN = -8'sd128;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_CALC = 3'd3,
        ST_WR   = 3'd4,
        ST_ACK  = 3'd5,
        ST_CLR  = 3'd6
    } state_t;

endpackage

// File: rtl/column_m10k.sv
// Simple dual-port column RAM: port A read/write, port B read-only,
// both with registered read data. Port B returns the old contents when
// it reads the cell port A is writing in the same cycle.
module column_m10k import heatmap_pkg::*; #(
    parameter int AW = heatmap_pkg::ROW_W,
    parameter int DW = heatmap_pkg::DATA_W
) (
    input  logic          clock,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic [DW-1:0] b_rdata
);

    // The array spans the full address width; the owner never writes or
    // presents a port-B address beyond its row count.
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Port A: write plus registered read of the same address.
    always_ff @(posedge clock) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        a_rdata <= mem[a_addr];
    end

    // Port B: registered read, no stall.
    always_ff @(posedge clock) begin
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/heat_column_store.sv
// One heat-map column: write FSM with saturating accumulate or overwrite,
// whole-column clear, and an independent VGA read port.
module heat_column_store import heatmap_pkg::*; #(
    parameter int ROWS   = heatmap_pkg::ROWS,
    parameter int ROW_W  = heatmap_pkg::ROW_W,
    parameter int DATA_W = heatmap_pkg::DATA_W,
    parameter int ACCUM  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sel,
    input  logic [ROW_W-1:0]  row,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ack,
    input  logic              clear,
    output logic              busy,
    input  logic [ROW_W-1:0]  vga_row,
    output logic [DATA_W-1:0] vga_data
);

    localparam logic [ROW_W-1:0]  ROWS_V   = ROW_W'(ROWS);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [DATA_W-1:0] S_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN    = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [ROW_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [ROW_W-1:0]  vga_addr_q, vga_addr_d;
    logic              vga_vld1_q, vga_vld1_d;
    logic              vga_vld2_q, vga_vld2_d;

    logic              ram_we;
    logic [ROW_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata_a;
    logic [DATA_W-1:0] ram_rdata_b;

    // Sign-extend both operands by one bit; a disagreement between the top
    // two sum bits means overflow, and the sign bit tells which rail.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) begin
            sat_add = s[DATA_W] ? S_MIN : S_MAX;
        end else begin
            sat_add = s[DATA_W-1:0];
        end
    endfunction

    assign ack  = (state_q == ST_ACK);
    assign busy = (state_q != ST_IDLE);

    // Next-state, latches and port-A control for the write/clear FSM.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        data_d    = data_q;
        result_d  = result_q;
        clr_cnt_d = clr_cnt_q;
        ram_we    = 1'b0;
        ram_addr  = row_q;
        ram_wdata = result_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    clr_cnt_d = '0;
                    state_d   = ST_CLR;
                end else if (sel && !ack) begin
                    row_d   = row;
                    data_d  = wr_data;
                    // Out-of-range rows are acknowledged without touching RAM.
                    state_d = (row < ROWS_V) ? ST_RD : ST_ACK;
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: state_d = ST_CALC;
            ST_CALC: begin
                result_d = (ACCUM != 0) ? sat_add(ram_rdata_a, data_q) : data_q;
                state_d  = ST_WR;
            end
            ST_WR: begin
                ram_we  = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!sel) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                ram_wdata = '0;
                if (clr_cnt_q == LAST_ROW) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // VGA address register with range flag carried alongside the RAM latency.
    always_comb begin
        vga_vld1_d = (vga_row < ROWS_V);
        vga_addr_d = vga_vld1_d ? vga_row : '0;
        vga_vld2_d = vga_vld1_q;
    end

    // State and pipeline registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            data_q     <= '0;
            result_q   <= '0;
            clr_cnt_q  <= '0;
            vga_addr_q <= '0;
            vga_vld1_q <= 1'b0;
            vga_vld2_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            data_q     <= data_d;
            result_q   <= result_d;
            clr_cnt_q  <= clr_cnt_d;
            vga_addr_q <= vga_addr_d;
            vga_vld1_q <= vga_vld1_d;
            vga_vld2_q <= vga_vld2_d;
        end
    end

    assign vga_data = vga_vld2_q ? ram_rdata_b : '0;

    column_m10k #(
        .AW (ROW_W),
        .DW (DATA_W)
    ) u_ram (
        .clock   (clock),
        .a_addr  (ram_addr),
        .a_we    (ram_we),
        .a_wdata (ram_wdata),
        .a_rdata (ram_rdata_a),
        .b_addr  (vga_addr_q),
        .b_rdata (ram_rdata_b)
    );

endmodule

// File: tb/tb_heat_column_store.sv
// Bench for heat_column_store: an overwrite instance and an accumulate
// instance share stimulus; a reference model predicts every VGA read.
module tb_heat_column_store;
    import heatmap_pkg::*;

    logic       clock = 1'b0;
    logic       reset, sel, clear;
    logic [9:0] row, vga_row;
    logic [7:0] wr_data;
    logic       ack_ov, ack_ac, busy_ov, busy_ac;
    logic [7:0] vd_ov, vd_ac;

    always #5 clock = ~clock;

    heat_column_store #(.ACCUM(0)) dut_ov (
        .clock(clock), .reset(reset), .sel(sel), .row(row), .wr_data(wr_data),
        .ack(ack_ov), .clear(clear), .busy(busy_ov), .vga_row(vga_row), .vga_data(vd_ov));

    heat_column_store #(.ACCUM(1)) dut_ac (
        .clock(clock), .reset(reset), .sel(sel), .row(row), .wr_data(wr_data),
        .ack(ack_ac), .clear(clear), .busy(busy_ac), .vga_row(vga_row), .vga_data(vd_ac));

    typedef struct { int edge_c; int r; int d; } wr_t;
    typedef struct { bit skip; int addr; int e_ov; int e_ac; } exp_t;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   m_ov [ROWS];
    int   m_ac [ROWS];
    wr_t  pend [$];
    exp_t sbq  [$];
    int   cyc        = 0;
    int   skip_until = 1000000;
    int   a_cap      = 0;
    int   force_row  = -1;
    int   sweep      = 0;

    task automatic check(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Reference: each edge, predict the read completing now from the model
    // state before this edge's write, then apply any write landing here.
    always @(posedge clock) begin : feeder
        int   rd;
        exp_t e;
        #1;
        cyc++;
        rd    = a_cap;
        a_cap = int'(vga_row);
        e.skip = (cyc < skip_until);
        e.addr = rd;
        e.e_ov = (rd < ROWS) ? m_ov[rd] : 0;
        e.e_ac = (rd < ROWS) ? m_ac[rd] : 0;
        sbq.push_back(e);
        if (pend.size() > 0 && pend[0].edge_c == cyc) begin
            m_ov[pend[0].r] = pend[0].d;
            m_ac[pend[0].r] = clamp8(m_ac[pend[0].r] + pend[0].d);
            void'(pend.pop_front());
        end
        if (force_row >= 0) vga_row = 10'(force_row);
        else if ($urandom_range(0, 3) == 0) vga_row = 10'($urandom_range(0, 520));
        else vga_row = 10'(sweep);
        sweep = (sweep + 1) % 495;
    end

    // Monitor: one VGA result per cycle, compared against the scoreboard.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (!e.skip) begin
                check($sformatf("vga_ov[%0d]", e.addr), int'($signed(vd_ov)), e.e_ov);
                check($sformatf("vga_acc[%0d]", e.addr), int'($signed(vd_ac)), e.e_ac);
            end
        end
    end

    task automatic wait_ack(input int exp_lat, input string nm);
        int n = 0;
        while (ack_ov !== 1'b1 && n < 700) begin
            @(negedge clock);
            n++;
        end
        check({nm, "_ack_latency"}, n, exp_lat);
        check({nm, "_ack_acc_inst"}, int'(ack_ac), 1);
    endtask

    task automatic do_write(input int r, input int d, input int hold, input bit early);
        int c0;
        @(negedge clock);
        sel = 1'b1; row = 10'(r); wr_data = d[7:0]; c0 = cyc;
        if (r < ROWS) pend.push_back('{c0 + 5, r, d});
        if (early) begin
            @(negedge clock);
            sel = 1'b0;
            wait_ack((r < ROWS) ? 4 : 0, $sformatf("wr%0d_early", r));
        end else begin
            wait_ack((r < ROWS) ? 5 : 1, $sformatf("wr%0d", r));
            repeat (hold) @(negedge clock);
            check("ack_held", int'(ack_ov), 1);
            sel = 1'b0;
        end
        @(negedge clock);
        check("ack_fall", int'(ack_ov), 0);
        check("busy_after_ack", int'(busy_ov | busy_ac), 0);
    endtask

    task automatic do_clear(input bit with_sel, input int r, input int d);
        int c0, run, bad;
        @(negedge clock);
        clear = 1'b1; c0 = cyc;
        for (int i = 0; i < ROWS; i++) begin m_ov[i] = 0; m_ac[i] = 0; end
        skip_until = c0 + 483;
        @(negedge clock);
        clear = 1'b0;
        if (with_sel) begin
            sel = 1'b1; row = 10'(r); wr_data = d[7:0];
            pend.push_back('{c0 + 486, r, d});
        end
        run = 0; bad = 0;
        while (busy_ov === 1'b1 && run < 600) begin
            if (ack_ov !== 1'b0 || busy_ac !== 1'b1) bad++;
            run++;
            @(negedge clock);
        end
        check("clear_busy_cycles", run, 480);
        check("clear_ack_low", bad, 0);
        if (with_sel) begin
            wait_ack(5, "post_clear");
            sel = 1'b0;
            @(negedge clock);
            check("post_clear_ack_fall", int'(ack_ov), 0);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int c0;
        reset = 1'b1; sel = 1'b0; clear = 1'b0; row = '0; wr_data = '0; vga_row = '0;
        repeat (3) @(negedge clock);
        check("rst_ack", int'(ack_ov | ack_ac), 0);
        check("rst_busy", int'(busy_ov | busy_ac), 0);
        check("rst_vga_ov", int'(vd_ov), 0);
        check("rst_vga_acc", int'(vd_ac), 0);
        reset = 1'b0;

        do_clear(1'b0, 0, 0);

        // Basic overwrite, then directed reads of that cell.
        force_row = 5;
        do_write(5, -20, 2, 1'b0);
        repeat (4) @(negedge clock);
        force_row = -1;

        // Accumulate and saturation cases.
        do_write(7, 120, 0, 1'b0);
        do_write(7, 10, 1, 1'b0);
        do_write(7, -128, 0, 1'b0);
        do_write(7, -128, 0, 1'b0);
        do_write(9, 127, 0, 1'b0);
        do_write(9, 5, 0, 1'b0);
        do_write(10, -128, 0, 1'b0);
        do_write(10, -1, 0, 1'b0);
        do_write(11, 100, 0, 1'b0);
        do_write(11, -30, 0, 1'b0);

        // Out of range write and read.
        force_row = 480;
        do_write(480, 33, 1, 1'b0);
        repeat (4) @(negedge clock);
        force_row = -1;

        // sel dropped before ack.
        do_write(12, 55, 0, 1'b1);
        do_write(600, 1, 0, 1'b1);

        // clear while busy is ignored.
        @(negedge clock);
        sel = 1'b1; row = 10'd13; wr_data = 8'd9; c0 = cyc;
        pend.push_back('{c0 + 5, 13, 9});
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        wait_ack(2, "busy_clear");
        sel = 1'b0;
        @(negedge clock);
        check("clear_not_queued", int'(busy_ov | busy_ac), 0);

        // Reset while in WAIT.
        @(negedge clock);
        sel = 1'b1; row = 10'd14; wr_data = 8'd77;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1; sel = 1'b0; skip_until = cyc + 4;
        @(negedge clock);
        check("midop_rst_ack", int'(ack_ov | ack_ac), 0);
        check("midop_rst_busy", int'(busy_ov | busy_ac), 0);
        reset = 1'b0;
        do_write(14, -3, 0, 1'b0);

        // Clear with a write queued right behind it.
        do_clear(1'b1, 3, -7);

        // Port B reading the very cell being written.
        force_row = 20;
        do_write(20, 42, 0, 1'b0);
        do_write(20, 100, 0, 1'b0);
        force_row = -1;

        // Randomized writes over a small row set to exercise accumulation.
        repeat (60) begin
            int r, d;
            r = ($urandom_range(0, 9) == 0) ? $urandom_range(480, 700) : $urandom_range(0, 15);
            d = $urandom_range(0, 255) - 128;
            do_write(r, d, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (10) @(negedge clock);
        check("pending_writes_drained", pend.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
